// File: rtl/nonce_select_if.sv
// -----------------------------------------------------------------------------
// nonce_select_if
// Word-wide read bus between nonce_select and the H0 result memory.
//   mem_clk        : memory clock, a copy of the block clock
//   mem_we         : write enable; the block only reads, so this is held at 0
//   mem_addr       : 16-bit word address
//   mem_write_data : write data; unused, held at 0
//   mem_read_data  : read data, valid one cycle after its address is presented
// Modports: master = nonce_select side, slave = memory side.
// -----------------------------------------------------------------------------
interface nonce_select_if;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output mem_clk,
      output mem_we,
      output mem_addr,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_clk,
      input  mem_we,
      input  mem_addr,
      input  mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/nonce_select.sv
// -----------------------------------------------------------------------------
// nonce_select
// Scans NUM_NONCE consecutive 32-bit H0 words starting at hash_addr. For each
// word it tracks the minimum value (with its index) and counts how many words
// fall strictly below target. The run takes NUM_NONCE+1 cycles from the start
// edge to the done pulse.
//
// Parameters:
//   NUM_NONCE   : words scanned per run, legal range 1..255
// Ports:
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   start       : run request, sampled only while idle
//   hash_addr   : base word address of the H0 array (latched at start)
//   target      : unsigned threshold (latched at start)
//   done        : one-cycle completion pulse
//   found       : at least one word strictly below target
//   best_nonce  : index of the minimum word (lowest index on ties)
//   min_hash    : minimum word value
//   match_count : number of words strictly below target
//   mem         : read bus to the H0 memory (master side)
// -----------------------------------------------------------------------------
module nonce_select #(
   parameter int NUM_NONCE = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [15:0]         hash_addr,
   input  logic [31:0]         target,
   output logic                done,
   output logic                found,
   output logic [7:0]          best_nonce,
   output logic [31:0]         min_hash,
   output logic [7:0]          match_count,
   nonce_select_if.master      mem
);

   localparam logic [7:0] IDX_MAX  = 8'(NUM_NONCE - 1);
   localparam logic [7:0] CNT_LAST = 8'(NUM_NONCE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] base_q;
   logic [31:0] target_q;
   logic [7:0]  rd_idx;
   logic [7:0]  cnt;
   logic        cap_vld_p1;
   logic [7:0]  cap_idx_p1;
   logic [31:0] rdata_p1;

   // Increment that sticks at a ceiling instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic [7:0] ceil);
      sat_inc8 = (val >= ceil) ? val : val + 8'd1;
   endfunction

   // Memory bus: read-only, address follows the read index only while scanning.
   assign mem.mem_clk        = clk;
   assign mem.mem_we         = 1'b0;
   assign mem.mem_write_data = 32'd0;
   assign mem.mem_addr       = (state == READ) ? (base_q + {8'd0, rd_idx}) : base_q;

   // ---- stage p0: address issue (rd_idx) / stage p1: data return ----
   // cnt counts cycles spent in READ. The word addressed in READ cycle j is
   // on mem_read_data during cycle j+1, so a capture happens whenever cnt is
   // non-zero and belongs to word index cnt-1. The capture at cnt==NUM_NONCE
   // is the last one and coincides with the move to DONE.
   assign rdata_p1   = mem.mem_read_data;
   assign cap_vld_p1 = (state == READ) && (cnt != 8'd0);
   assign cap_idx_p1 = cnt - 8'd1;

   assign found = (match_count != 8'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = READ;
         end
         READ: begin
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q      <= 16'd0;
         target_q    <= 32'd0;
         rd_idx      <= 8'd0;
         cnt         <= 8'd0;
         match_count <= 8'd0;
         min_hash    <= 32'hFFFF_FFFF;
         best_nonce  <= 8'd0;
      end else begin
         if (state == IDLE && start) begin
            base_q      <= hash_addr;
            target_q    <= target;
            rd_idx      <= 8'd0;
            cnt         <= 8'd0;
            match_count <= 8'd0;
            min_hash    <= 32'hFFFF_FFFF;
            best_nonce  <= 8'd0;
         end else if (state == READ) begin
            rd_idx <= sat_inc8(rd_idx, IDX_MAX);
            cnt    <= cnt + 8'd1;
            if (cap_vld_p1) begin
               if (rdata_p1 < target_q) begin
                  match_count <= sat_inc8(match_count, 8'hFF);
               end
               // Strict compare keeps the earlier index on equal values.
               if (rdata_p1 < min_hash) begin
                  min_hash   <= rdata_p1;
                  best_nonce <= cap_idx_p1;
               end
            end
         end
      end
   end

endmodule
